// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl: SFP module link bring-up FSM with synchronised, debounced LOS/TX_FAULT inputs.
// Latency: input to filtered value is 2 + DEB_CYC cycles; the FSM reacts on the following edge.
// Backpressure: none; outputs are registered-state decodes and the enable request is level sensitive.
// Optional feature macro: SFP_AUTO_RETRY_EN (automatic TX re-init from FAULT, bounded by MAX_RETRY).

// Two-flop synchroniser followed by a consecutive-mismatch debouncer; resets pessimistic (1).
module sfp_link_deb #(
  parameter int DEB_CYC = 60
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_async,
  output logic o_filt
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_async;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEB_CYC consecutive cycles of disagreement.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync2 != filt) begin
      if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign o_filt = filt;

endmodule

module sfp_link_ctrl #(
  parameter int DEB_CYC    = 60,
  parameter int T_OFF_CYC  = 600,
  parameter int T_INIT_CYC = 60000,
  parameter int MAX_RETRY  = 7
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_enable,
  input  logic       i_sfp_los,
  input  logic       i_sfp_tx_flt,
  input  logic       i_fault_clr,
  output logic       o_sfp_tx_dis_n,
  output logic       o_tx_en,
  output logic       o_rx_valid,
  output logic       o_link_up,
  output logic       o_fault,
  output logic [2:0] o_state,
  output logic [3:0] o_retry_cnt
);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_TXRST = 3'd1;
  localparam logic [2:0] ST_INIT  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_UP    = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam int T_MAX = (T_INIT_CYC > T_OFF_CYC) ? T_INIT_CYC : T_OFF_CYC;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] T_OFF_LAST  = TW'(T_OFF_CYC - 1);
  localparam logic [TW-1:0] T_INIT_LAST = TW'(T_INIT_CYC - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  logic          los_f;
  logic          flt_f;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] timer;
  logic [3:0]    retry_cnt;
  logic          tmr_off_done;
  logic          tmr_init_done;
  logic          auto_retry;
  logic          retry_inc;
  logic          retry_clr;

  sfp_link_deb #(.DEB_CYC(DEB_CYC)) u_deb_los (
    .i_clk   (i_clk),
    .i_res_n (i_res_n),
    .i_async (i_sfp_los),
    .o_filt  (los_f)
  );

  sfp_link_deb #(.DEB_CYC(DEB_CYC)) u_deb_flt (
    .i_clk   (i_clk),
    .i_res_n (i_res_n),
    .i_async (i_sfp_tx_flt),
    .o_filt  (flt_f)
  );

  // Timer value N-1 marks the N-th cycle spent in the current state.
  assign tmr_off_done  = (timer == T_OFF_LAST);
  assign tmr_init_done = (timer == T_INIT_LAST);

`ifdef SFP_AUTO_RETRY_EN
  assign auto_retry = (state == ST_FAULT) && tmr_off_done && (retry_cnt < RETRY_MAX);
`else
  assign auto_retry = 1'b0;
`endif

  // Next-state selection; dropping the enable overrides every other condition.
  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:   state_nxt = ST_TXRST;
        ST_TXRST: if (tmr_off_done) state_nxt = ST_INIT;
        ST_INIT:  if (tmr_init_done) state_nxt = flt_f ? ST_FAULT : ST_WAIT;
        ST_WAIT: begin
          if (flt_f)       state_nxt = ST_FAULT;
          else if (!los_f) state_nxt = ST_UP;
        end
        ST_UP: begin
          if (flt_f)      state_nxt = ST_FAULT;
          else if (los_f) state_nxt = ST_WAIT;
        end
        ST_FAULT: begin
          if (i_fault_clr)     state_nxt = ST_TXRST;
          else if (auto_retry) state_nxt = ST_TXRST;
        end
        default:  state_nxt = ST_OFF;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) state <= ST_OFF;
    else          state <= state_nxt;
  end

  // Shared dwell timer: zero on every state entry, then counts up and saturates.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      timer <= '0;
    end else if (timer != {TW{1'b1}}) begin
      timer <= timer + 1'b1;
    end
  end

  // A retry is only counted when the FSM actually leaves FAULT on its own.
  assign retry_inc = auto_retry && i_enable && !i_fault_clr;
  assign retry_clr = i_fault_clr || (state == ST_OFF) ||
                     ((state_nxt == ST_UP) && (state != ST_UP));

  // Retry counter; increments are already gated below RETRY_MAX so it cannot wrap.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      retry_cnt <= 4'd0;
    end else if (retry_clr) begin
      retry_cnt <= 4'd0;
    end else if (retry_inc && (retry_cnt < RETRY_MAX)) begin
      retry_cnt <= retry_cnt + 4'd1;
    end
  end

  assign o_sfp_tx_dis_n = (state == ST_INIT) || (state == ST_WAIT) || (state == ST_UP);
  assign o_tx_en        = (state == ST_WAIT) || (state == ST_UP);
  assign o_rx_valid     = (state == ST_UP);
  assign o_link_up      = (state == ST_UP);
  assign o_fault        = (state == ST_FAULT);
  assign o_state        = state;
  assign o_retry_cnt    = retry_cnt;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
module tb_sfp_link_ctrl;

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_TXRST = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_UP    = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       enable = 1'b0;
  logic       los = 1'b1;
  logic       flt = 1'b1;
  logic       fault_clr = 1'b0;
  logic       tx_dis_n;
  logic       tx_en;
  logic       rx_valid;
  logic       link_up;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry;

  int n_cmp = 0;
  int n_err = 0;

  sfp_link_ctrl #(
    .DEB_CYC(4), .T_OFF_CYC(8), .T_INIT_CYC(32), .MAX_RETRY(3)
  ) dut (
    .i_clk          (clk),
    .i_res_n        (res_n),
    .i_enable       (enable),
    .i_sfp_los      (los),
    .i_sfp_tx_flt   (flt),
    .i_fault_clr    (fault_clr),
    .o_sfp_tx_dis_n (tx_dis_n),
    .o_tx_en        (tx_en),
    .o_rx_valid     (rx_valid),
    .o_link_up      (link_up),
    .o_fault        (fault),
    .o_state        (state),
    .o_retry_cnt    (retry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b0; enable = 1'b0; los = 1'b1; flt = 1'b1; fault_clr = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (state !== S_OFF) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state, S_OFF); end
    n_cmp++;
    if ({tx_dis_n, tx_en, rx_valid, link_up, fault} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 00000", {tx_dis_n, tx_en, rx_valid, link_up, fault});
    end
    n_cmp++;
    if (retry !== 4'd0) begin n_err++; $display("FAIL reset_retry: got %0d want 0", retry); end
  endtask

  task automatic test_bringup();
    int n;
    los = 1'b0; flt = 1'b0; enable = 1'b1; res_n = 1'b1;
    tick();
    n_cmp++;
    if (state !== S_TXRST) begin n_err++; $display("FAIL bringup_txrst: got %0d want %0d", state, S_TXRST); end
    n_cmp++;
    if (tx_dis_n !== 1'b0) begin n_err++; $display("FAIL bringup_laser_off: got %b want 0", tx_dis_n); end
    n = 0;
    while (state == S_TXRST && n < 100) begin n++; tick(); end
    n_cmp++;
    if (n != 8) begin n_err++; $display("FAIL txrst_len: got %0d want 8", n); end
    n_cmp++;
    if (state !== S_INIT || tx_dis_n !== 1'b1 || tx_en !== 1'b0) begin
      n_err++; $display("FAIL init_entry: state %0d dis_n %b tx_en %b want 2 1 0", state, tx_dis_n, tx_en);
    end
    n = 0;
    while (state == S_INIT && n < 100) begin n++; tick(); end
    n_cmp++;
    if (n != 32) begin n_err++; $display("FAIL init_len: got %0d want 32", n); end
    n_cmp++;
    if (state !== S_WAIT || tx_en !== 1'b1 || rx_valid !== 1'b0) begin
      n_err++; $display("FAIL wait_entry: state %0d tx_en %b rx_valid %b want 3 1 0", state, tx_en, rx_valid);
    end
    n = 0;
    while (state != S_UP && n < 6) begin n++; tick(); end
    n_cmp++;
    if (state !== S_UP || link_up !== 1'b1 || rx_valid !== 1'b1) begin
      n_err++; $display("FAIL up_entry: state %0d link %b rx %b want 4 1 1", state, link_up, rx_valid);
    end
  endtask

  task automatic test_glitch();
    int bad;
    int n;
    bad = 0;
    los = 1'b1;
    repeat (3) begin tick(); if (state !== S_UP) bad++; end
    los = 1'b0;
    repeat (10) begin tick(); if (state !== S_UP) bad++; end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL short_pulse: got %0d non-UP cycles want 0", bad); end
    bad = 0;
    los = 1'b1;
    repeat (6) begin tick(); if (state !== S_UP) bad++; end
    los = 1'b0;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL long_pulse_early: got %0d non-UP cycles want 0", bad); end
    tick();
    n_cmp++;
    if (state !== S_WAIT || rx_valid !== 1'b0 || link_up !== 1'b0 || tx_en !== 1'b1) begin
      n_err++; $display("FAIL long_pulse_wait: state %0d rx %b link %b tx_en %b want 3 0 0 1", state, rx_valid, link_up, tx_en);
    end
    n = 0;
    while (state == S_WAIT && n < 50) begin n++; tick(); end
    n_cmp++;
    if (n != 6 || state !== S_UP) begin n_err++; $display("FAIL relink: got %0d cycles state %0d want 6 cycles state 4", n, state); end
  endtask

`ifdef SFP_AUTO_RETRY_EN
  task automatic test_fault();
    int retries;
    logic [2:0] prev;
    flt = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if (state !== S_FAULT || tx_dis_n !== 1'b0) begin
      n_err++; $display("FAIL fault_entry: state %0d dis_n %b want 5 0", state, tx_dis_n);
    end
    retries = 0;
    prev = state;
    repeat (400) begin
      tick();
      if (prev == S_FAULT && state == S_TXRST) retries++;
      prev = state;
    end
    n_cmp++;
    if (retries != 3) begin n_err++; $display("FAIL retry_count: got %0d want 3", retries); end
    n_cmp++;
    if (retry !== 4'd3 || state !== S_FAULT || fault !== 1'b1) begin
      n_err++; $display("FAIL retry_lock: retry %0d state %0d want 3 5", retry, state);
    end
    fault_clr = 1'b1; flt = 1'b0;
    tick();
    fault_clr = 1'b0;
    n_cmp++;
    if (state !== S_TXRST || retry !== 4'd0) begin
      n_err++; $display("FAIL fault_clr: state %0d retry %0d want 1 0", state, retry);
    end
  endtask
`else
  task automatic test_fault();
    int bad;
    bad = 0;
    flt = 1'b1;
    repeat (6) begin tick(); if (state !== S_UP) bad++; end
    tick();
    n_cmp++;
    if (bad != 0 || state !== S_FAULT) begin n_err++; $display("FAIL fault_entry: state %0d early %0d want 5 0", state, bad); end
    n_cmp++;
    if (tx_dis_n !== 1'b0 || fault !== 1'b1 || tx_en !== 1'b0) begin
      n_err++; $display("FAIL fault_outputs: dis_n %b fault %b tx_en %b want 0 1 0", tx_dis_n, fault, tx_en);
    end
    repeat (3) tick();
    flt = 1'b0;
    bad = 0;
    repeat (60) begin tick(); if (state !== S_FAULT) bad++; end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL fault_hold: got %0d non-FAULT cycles want 0", bad); end
    n_cmp++;
    if (retry !== 4'd0) begin n_err++; $display("FAIL fault_retry: got %0d want 0", retry); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    n_cmp++;
    if (state !== S_TXRST || fault !== 1'b0) begin n_err++; $display("FAIL fault_clr: state %0d fault %b want 1 0", state, fault); end
  endtask
`endif

  task automatic test_priority();
    int n;
    int bad;
    los = 1'b1;
    n = 0;
    while (state != S_WAIT && n < 200) begin n++; tick(); end
    n_cmp++;
    if (state !== S_WAIT) begin n_err++; $display("FAIL prio_reach_wait: got %0d want 3", state); end
    bad = 0;
    flt = 1'b1;
    repeat (6) begin tick(); if (state !== S_WAIT) bad++; end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (bad != 0 || state !== S_OFF) begin n_err++; $display("FAIL prio_off: state %0d early %0d want 0 0", state, bad); end
    n_cmp++;
    if ({tx_dis_n, tx_en, rx_valid, link_up, fault} !== 5'b0) begin
      n_err++; $display("FAIL prio_outputs: got %b want 00000", {tx_dis_n, tx_en, rx_valid, link_up, fault});
    end
  endtask

  task automatic test_reset_mid_init();
    int n;
    flt = 1'b0; los = 1'b0; enable = 1'b1;
    n = 0;
    while (state != S_INIT && n < 100) begin n++; tick(); end
    repeat (5) tick();
    n_cmp++;
    if (state !== S_INIT) begin n_err++; $display("FAIL mid_init_reach: got %0d want 2", state); end
    res_n = 1'b0;
    #1;
    n_cmp++;
    if (state !== S_OFF || {tx_dis_n, tx_en, rx_valid, link_up, fault} !== 5'b0 || retry !== 4'd0) begin
      n_err++; $display("FAIL mid_init_reset: state %0d outs %b retry %0d want 0 00000 0", state,
                        {tx_dis_n, tx_en, rx_valid, link_up, fault}, retry);
    end
    tick();
    enable = 1'b0;
    res_n = 1'b1;
    tick();
    n_cmp++;
    if (state !== S_OFF || tx_dis_n !== 1'b0) begin n_err++; $display("FAIL post_reset_off: state %0d dis_n %b want 0 0", state, tx_dis_n); end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (state !== S_TXRST) begin n_err++; $display("FAIL restart_txrst: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_fault();
    test_priority();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
